// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one registered ALU between NUM_REQ requesters. A winner is chosen
// while idle, its operands and control code are registered onto the ALU bus,
// the block waits out the ALU pipeline latency, then presents the captured
// result, zero flag and winner index on a valid/ready response channel.
// Only one operation is ever in flight.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   WIDTH        operand / result width
//   ALU_LATENCY  cycles from operands on the ALU bus to a valid alu_result (1..7)
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   req_valid[NUM_REQ]        per-requester request valid
//   req_ready[NUM_REQ]        per-requester accept (one-hot or zero, idle only)
//   req_a / req_b             packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ctrl                  packed 4-bit ALU control codes, requester i at [i*4 +: 4]
//   alu_operand_a/b, alu_ctrl registered drive to the shared ALU
//   alu_result, alu_zero      ALU outputs, sampled at the end of the wait
//   rsp_valid / rsp_ready     response handshake
//   rsp_result, rsp_zero      captured ALU outputs
//   rsp_id                    index of the requester owning the response
//   busy                      high whenever an operation is in flight
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN     when defined, the lowest-index valid requester
//                             always wins and no round-robin pointer exists.
//                             Undefined (default): round-robin arbitration.
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 32,
   parameter int ALU_LATENCY = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ*4-1:0]       req_ctrl,
   output logic [WIDTH-1:0]           alu_operand_a,
   output logic [WIDTH-1:0]           alu_operand_b,
   output logic [3:0]                 alu_ctrl,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic                       alu_zero,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_result,
   output logic                       rsp_zero,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic                       busy
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int CNTW = $clog2(ALU_LATENCY + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       r_state;
   logic [CNTW-1:0]  r_count;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic [3:0]       r_ctrl;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_rspResult;
   logic             r_rspZero;

   logic             w_grantValid;
   logic [IDW-1:0]   w_grantIdx;
   logic             w_accept;
   logic             w_lastWait;
   logic [WIDTH-1:0] w_selA;
   logic [WIDTH-1:0] w_selB;
   logic [3:0]       w_selCtrl;
   logic [NUM_REQ-1:0] w_reqReady;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: scanning from the top down lets the lowest valid index
   // overwrite any higher one, so the lowest index wins.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] r_rrPtr;

   // Round-robin: walk the requesters starting at the pointer and wrapping.
   // The walk runs from the furthest offset back to offset zero so the
   // nearest valid requester at or after the pointer is the one left standing.
   always_comb begin
      int idx;
      idx          = 0;
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(r_rrPtr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_valid[IDW'(idx)]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = IDW'(idx);
         end
      end
   end

   // The pointer moves just past the winner on every accept so the winner
   // gets lowest priority in the next arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rrPtr <= '0;
      end else if (w_accept) begin
         if (w_grantIdx == IDW'(NUM_REQ - 1)) begin
            r_rrPtr <= '0;
         end else begin
            r_rrPtr <= w_grantIdx + IDW'(1);
         end
      end
   end
`endif

   // A request is only ever taken while idle, which keeps exactly one
   // operation in flight and keeps the response and next accept apart.
   assign w_accept   = (r_state == S_IDLE) && w_grantValid;
   assign w_lastWait = (r_state == S_WAIT) && (r_count == CNTW'(1));

   // Pick the winner's operand slices; the loop keeps every slice index
   // constant so no variable part-select is needed.
   always_comb begin
      w_selA     = '0;
      w_selB     = '0;
      w_selCtrl  = '0;
      w_reqReady = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grantIdx == IDW'(i)) begin
            w_selA     = req_a[i*WIDTH +: WIDTH];
            w_selB     = req_b[i*WIDTH +: WIDTH];
            w_selCtrl  = req_ctrl[i*4 +: 4];
            w_reqReady[i] = w_accept;
         end
      end
   end

   // Control FSM. The counter is loaded in ISSUE and counts the WAIT cycles
   // down, so the final WAIT cycle is the one where it reads 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_count <= CNTW'(ALU_LATENCY);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_count <= r_count - CNTW'(1);
               if (r_count == CNTW'(1)) begin
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   // ALU bus registers only change on an accept, so they hold steady through
   // ISSUE and WAIT and keep their last values afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opA  <= '0;
         r_opB  <= '0;
         r_ctrl <= '0;
         r_id   <= '0;
      end else if (w_accept) begin
         r_opA  <= w_selA;
         r_opB  <= w_selB;
         r_ctrl <= w_selCtrl;
         r_id   <= w_grantIdx;
      end
   end

   // The ALU output is sampled on the edge closing the last WAIT cycle and
   // then held until the next operation completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rspResult <= '0;
         r_rspZero   <= 1'b0;
      end else if (w_lastWait) begin
         r_rspResult <= alu_result;
         r_rspZero   <= alu_zero;
      end
   end

   assign req_ready     = w_reqReady;
   assign alu_operand_a = r_opA;
   assign alu_operand_b = r_opB;
   assign alu_ctrl      = r_ctrl;
   assign rsp_valid     = (r_state == S_RESP);
   assign rsp_result    = r_rspResult;
   assign rsp_zero      = r_rspZero;
   assign rsp_id        = r_id;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Main instance, ALU_LATENCY = 1
   logic [N-1:0]   reqValid;
   logic [N-1:0]   reqReady;
   logic [N*W-1:0] reqA;
   logic [N*W-1:0] reqB;
   logic [N*4-1:0] reqCtrl;
   logic [W-1:0]   aluA;
   logic [W-1:0]   aluB;
   logic [3:0]     aluCtrl;
   logic [W-1:0]   aluResult;
   logic           aluZero;
   logic           rspValid;
   logic           rspReady;
   logic [W-1:0]   rspResult;
   logic           rspZero;
   logic [1:0]     rspId;
   logic           busy;

   // Second instance, ALU_LATENCY = 3
   logic [N-1:0]   r3Valid;
   logic [N-1:0]   r3Ready;
   logic [N*W-1:0] r3A;
   logic [N*W-1:0] r3B;
   logic [N*4-1:0] r3Ctrl;
   logic [W-1:0]   alu3A;
   logic [W-1:0]   alu3B;
   logic [3:0]     alu3Ctrl;
   logic [W-1:0]   alu3Result;
   logic           alu3Zero;
   logic           rsp3Valid;
   logic           rsp3Ready;
   logic [W-1:0]   rsp3Result;
   logic           rsp3Zero;
   logic [1:0]     rsp3Id;
   logic           busy3;

   int checks   = 0;
   int failures = 0;
   int rrPtr    = 0;

   alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_ready(reqReady),
      .req_a(reqA), .req_b(reqB), .req_ctrl(reqCtrl),
      .alu_operand_a(aluA), .alu_operand_b(aluB), .alu_ctrl(aluCtrl),
      .alu_result(aluResult), .alu_zero(aluZero),
      .rsp_valid(rspValid), .rsp_ready(rspReady),
      .rsp_result(rspResult), .rsp_zero(rspZero), .rsp_id(rspId),
      .busy(busy)
   );

   alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(r3Valid), .req_ready(r3Ready),
      .req_a(r3A), .req_b(r3B), .req_ctrl(r3Ctrl),
      .alu_operand_a(alu3A), .alu_operand_b(alu3B), .alu_ctrl(alu3Ctrl),
      .alu_result(alu3Result), .alu_zero(alu3Zero),
      .rsp_valid(rsp3Valid), .rsp_ready(rsp3Ready),
      .rsp_result(rsp3Result), .rsp_zero(rsp3Zero), .rsp_id(rsp3Id),
      .busy(busy3)
   );

   // Behavioural ALU used both as the DUT's ALU and as the reference
   function automatic logic [31:0] aluOp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
      case (c)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         4'b0101: return a << b[4:0];
         4'b0110: return a >> b[4:0];
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Registered ALU pipelines of depth 1 and 3
   logic [W-1:0] pipe1;
   logic [W-1:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= aluOp(aluA, aluB, aluCtrl);
      pipe3[0] <= aluOp(alu3A, alu3B, alu3Ctrl);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign aluResult  = pipe1;
   assign aluZero    = (pipe1 == '0);
   assign alu3Result = pipe3[2];
   assign alu3Zero   = (pipe3[2] == '0);

   // Reference arbitration: first valid index at or after the pointer
   function automatic int expectGrant(input logic [3:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (v[i]) return i;
`else
      for (int k = 0; k < N; k++) if (v[(rrPtr + k) % N]) return (rrPtr + k) % N;
`endif
      return -1;
   endfunction

   task automatic modelAccept(input int g);
`ifndef ALU_ARB_FIXED_PRIO_EN
      rrPtr = (g + 1) % N;
`endif
   endtask

   function automatic logic [31:0] expResult(input int g);
      return aluOp(reqA[g*W +: W], reqB[g*W +: W], reqCtrl[g*4 +: 4]);
   endfunction

   task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
      reqA[i*W +: W] = a;
      reqB[i*W +: W] = b;
      reqCtrl[i*4 +: 4] = c;
   endtask

   task automatic applyStimulus();
      reqA     = {$urandom(), $urandom(), $urandom(), $urandom()};
      reqB     = {$urandom(), $urandom(), $urandom(), $urandom()};
      reqCtrl  = 16'($urandom());
      reqValid = 4'($urandom());
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rrPtr = 0;
      #1;
   endtask

   // Drives one transaction on the main instance and reports what it saw.
   // Called just after a falling edge with the DUT idle; returns just after
   // the falling edge where the DUT should be idle again.
   task automatic runTxn(input logic [3:0] valids, input int stall,
                         output logic [3:0] readySeen, output int lat,
                         output logic [31:0] res, output logic z, output logic [1:0] id,
                         output bit quietOk, output bit holdOk, output bit idleOk);
      quietOk = 1'b1;
      holdOk  = 1'b1;
      idleOk  = 1'b1;
      res = '0; z = 1'b0; id = '0;
      reqValid = valids;
      rspReady = 1'b0;
      #1;
      readySeen = reqReady;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         applyStimulus();
         #1;
         if (reqReady !== '0 || busy !== 1'b1) quietOk = 1'b0;
      end while (rspValid !== 1'b1 && lat < 30);
      if (rspValid !== 1'b1) lat = -1;
      res = rspResult;
      z   = rspZero;
      id  = rspId;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         applyStimulus();
         #1;
         if (rspValid !== 1'b1 || rspResult !== res || rspZero !== z || rspId !== id ||
             reqReady !== '0)
            holdOk = 1'b0;
      end
      rspReady = 1'b1;
      @(negedge clk);
      reqValid = '0;
      rspReady = 1'b0;
      #1;
      if (busy !== 1'b0 || rspValid !== 1'b0) idleOk = 1'b0;
   endtask

   task automatic test_reset_values();
      logic [109:0] all1;
      logic [109:0] all3;
      rst = 1'b1;
      reqValid = '0; reqA = '0; reqB = '0; reqCtrl = '0; rspReady = 1'b0;
      r3Valid = '0; r3A = '0; r3B = '0; r3Ctrl = '0; rsp3Ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      all1 = {reqReady, aluA, aluB, aluCtrl, rspValid, rspResult, rspZero, rspId, busy};
      all3 = {r3Ready, alu3A, alu3B, alu3Ctrl, rsp3Valid, rsp3Result, rsp3Zero, rsp3Id, busy3};
      checks++;
      if (all1 !== '0) begin
         failures++;
         $display("[TB] FAIL reset_values got=%h exp=0", all1);
      end
      checks++;
      if (all3 !== '0) begin
         failures++;
         $display("[TB] FAIL reset_values_lat3 got=%h exp=0", all3);
      end
      @(negedge clk);
      rst = 1'b0;
      rrPtr = 0;
      #1;
   endtask

   task automatic test_single_add();
      logic [3:0] rdy; int lat; logic [31:0] res; logic z; logic [1:0] id;
      bit qOk, hOk, iOk; int g;
      setReq(0, 32'd10, 32'd20, 4'b0000);
      g = expectGrant(4'b0001);
      runTxn(4'b0001, 0, rdy, lat, res, z, id, qOk, hOk, iOk);
      modelAccept(g);
      checks++;
      if (rdy !== 4'b0001) begin failures++; $display("[TB] FAIL add_ready got=%b exp=0001", rdy); end
      checks++;
      if (lat !== 3) begin failures++; $display("[TB] FAIL add_latency got=%0d exp=3", lat); end
      checks++;
      if (res !== 32'd30) begin failures++; $display("[TB] FAIL add_result got=%0d exp=30", res); end
      checks++;
      if (z !== 1'b0 || id !== 2'd0) begin
         failures++; $display("[TB] FAIL add_zero_id got=%b/%0d exp=0/0", z, id);
      end
      checks++;
      if (!(qOk && iOk)) begin
         failures++; $display("[TB] FAIL add_quiet_idle got=%b%b exp=11", qOk, iOk);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] rdy; int lat; logic [31:0] res; logic z; logic [1:0] id;
      bit qOk, hOk, iOk; int g; logic [31:0] er;
      pulseReset();
      for (int t = 0; t < 5; t++) begin
         setReq(0, 32'd30, 32'd10, 4'b0001);
         setReq(1, 32'h0000F0F0, 32'h00000FF0, 4'b0010);
         setReq(2, 32'd1, 32'd5, 4'b0101);
         setReq(3, 32'd10, 32'd20, 4'b0000);
         g  = expectGrant(4'b1111);
         er = expResult(g);
         runTxn(4'b1111, 0, rdy, lat, res, z, id, qOk, hOk, iOk);
         modelAccept(g);
         checks++;
         if (rdy !== (4'b0001 << g) || id !== 2'(g)) begin
            failures++;
            $display("[TB] FAIL rr_grant[%0d] got=%b/%0d exp=%b/%0d", t, rdy, id, 4'b0001 << g, g);
         end
         checks++;
         if (res !== er || lat !== 3) begin
            failures++;
            $display("[TB] FAIL rr_result[%0d] got=%h/%0d exp=%h/3", t, res, lat, er);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] rdy; int lat; logic [31:0] res; logic z; logic [1:0] id;
      bit qOk, hOk, iOk; int g; logic [31:0] er;
      applyStimulus();
      reqCtrl[2*4 +: 4] = 4'b0000;
      g  = expectGrant(4'b0100);
      er = expResult(g);
      runTxn(4'b0100, 5, rdy, lat, res, z, id, qOk, hOk, iOk);
      modelAccept(g);
      checks++;
      if (!hOk) begin failures++; $display("[TB] FAIL bp_hold got=%b exp=1", hOk); end
      checks++;
      if (!(qOk && iOk)) begin
         failures++; $display("[TB] FAIL bp_quiet_idle got=%b%b exp=11", qOk, iOk);
      end
      checks++;
      if (res !== er || id !== 2'd2) begin
         failures++; $display("[TB] FAIL bp_result got=%h/%0d exp=%h/2", res, id, er);
      end
   endtask

   task automatic test_zero_flag();
      logic [3:0] rdy; int lat; logic [31:0] res; logic z; logic [1:0] id;
      bit qOk, hOk, iOk; int g;
      setReq(3, 32'd10, 32'd10, 4'b0001);
      g = expectGrant(4'b1000);
      runTxn(4'b1000, 1, rdy, lat, res, z, id, qOk, hOk, iOk);
      modelAccept(g);
      checks++;
      if (res !== 32'd0 || z !== 1'b1) begin
         failures++; $display("[TB] FAIL zero_flag got=%h/%b exp=0/1", res, z);
      end
      checks++;
      if (id !== 2'd3) begin failures++; $display("[TB] FAIL zero_id got=%0d exp=3", id); end
   endtask

   task automatic test_latency3();
      int lat;
      r3A = '0; r3B = '0; r3Ctrl = '0;
      r3A[0 +: W] = 32'd10;
      r3B[0 +: W] = 32'd20;
      r3Valid = 4'b0001;
      rsp3Ready = 1'b0;
      #1;
      checks++;
      if (r3Ready !== 4'b0001) begin failures++; $display("[TB] FAIL lat3_ready got=%b exp=0001", r3Ready); end
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         r3Valid = '0;
         #1;
      end while (rsp3Valid !== 1'b1 && lat < 30);
      checks++;
      if (lat !== 5) begin failures++; $display("[TB] FAIL lat3_latency got=%0d exp=5", lat); end
      checks++;
      if (rsp3Result !== 32'd30 || rsp3Zero !== 1'b0 || rsp3Id !== 2'd0) begin
         failures++;
         $display("[TB] FAIL lat3_result got=%0d/%b/%0d exp=30/0/0", rsp3Result, rsp3Zero, rsp3Id);
      end
      rsp3Ready = 1'b1;
      @(negedge clk);
      rsp3Ready = 1'b0;
      #1;
      checks++;
      if (busy3 !== 1'b0) begin failures++; $display("[TB] FAIL lat3_idle got=%b exp=0", busy3); end
   endtask

   task automatic test_reset();
      logic [109:0] all1;
      logic [109:0] all3;
      bit spurious;
      setReq(1, 32'd7, 32'd9, 4'b0000);
      r3A[1*W +: W] = 32'd7;
      r3B[1*W +: W] = 32'd9;
      reqValid = 4'b0010;
      r3Valid  = 4'b0010;
      rspReady = 1'b0;
      rsp3Ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reqValid = '0;
      r3Valid  = '0;
      repeat (2) @(negedge clk);
      // main instance is in RESP, latency-3 instance in its second WAIT cycle
      rst = 1'b1;
      #1;
      all1 = {reqReady, aluA, aluB, aluCtrl, rspValid, rspResult, rspZero, rspId, busy};
      all3 = {r3Ready, alu3A, alu3B, alu3Ctrl, rsp3Valid, rsp3Result, rsp3Zero, rsp3Id, busy3};
      checks++;
      if (all1 !== '0) begin failures++; $display("[TB] FAIL reset_mid_resp got=%h exp=0", all1); end
      checks++;
      if (all3 !== '0) begin failures++; $display("[TB] FAIL reset_mid_wait got=%h exp=0", all3); end
      @(negedge clk);
      rst = 1'b0;
      rrPtr = 0;
      rspReady = 1'b1;
      rsp3Ready = 1'b1;
      spurious = 1'b0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (rspValid !== 1'b0 || rsp3Valid !== 1'b0 || busy !== 1'b0 || busy3 !== 1'b0)
            spurious = 1'b1;
      end
      rspReady = 1'b0;
      rsp3Ready = 1'b0;
      checks++;
      if (spurious) begin failures++; $display("[TB] FAIL reset_no_response got=1 exp=0"); end
   endtask

   task automatic test_random();
      logic [3:0] rdy; int lat; logic [31:0] res; logic z; logic [1:0] id;
      bit qOk, hOk, iOk; int g; logic [31:0] er; logic [3:0] v; int stall;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            reqValid = '0;
            #1;
            checks++;
            if (reqReady !== '0 || busy !== 1'b0) begin
               failures++;
               $display("[TB] FAIL rand_idle[%0d] got=%b/%b exp=0000/0", t, reqReady, busy);
            end
            @(negedge clk);
            #1;
         end else begin
            applyStimulus();
            v     = 4'($urandom_range(1, 15));
            stall = $urandom_range(0, 3);
            g     = expectGrant(v);
            er    = expResult(g);
            runTxn(v, stall, rdy, lat, res, z, id, qOk, hOk, iOk);
            modelAccept(g);
            checks++;
            if (rdy !== (4'b0001 << g) || id !== 2'(g)) begin
               failures++;
               $display("[TB] FAIL rand_grant[%0d] got=%b/%0d exp=%b/%0d", t, rdy, id, 4'b0001 << g, g);
            end
            checks++;
            if (res !== er || z !== (er == 32'd0) || lat !== 3) begin
               failures++;
               $display("[TB] FAIL rand_result[%0d] got=%h/%b/%0d exp=%h/%b/3", t, res, z, lat, er, er == 32'd0);
            end
            checks++;
            if (!(qOk && hOk && iOk)) begin
               failures++;
               $display("[TB] FAIL rand_protocol[%0d] got=%b%b%b exp=111", t, qOk, hOk, iOk);
            end
         end
      end
   endtask

   initial begin
      test_reset_values();
      test_single_add();
      test_round_robin();
      test_backpressure();
      test_zero_flag();
      test_latency3();
      test_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running exp=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one registered ALU between NUM_REQ requesters. Each requester submits operands and a 4-bit ALU control code over a valid/ready handshake. The arbiter picks a winner round-robin, drives the shared ALU, waits out the ALU pipeline latency and returns the result, zero flag and winner ID over a valid/ready response channel. Exactly one operation is in flight at a time; the block sits between the issue logic and the ALU instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 32: operand and result width.
- ALU_LATENCY, 1: cycles from operands on alu_operand_a/b to a valid alu_result, 1..7.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_ctrl  input  NUM_REQ*4  ALU control codes, same packing: 0000 ADD, 0001 SUB, 0010 AND, 0101 SLL, other codes as the ALU defines them.
- alu_operand_a  output  WIDTH  to ALU operand_a; registered.
- alu_operand_b  output  WIDTH  to ALU operand_b; registered.
- alu_ctrl  output  4  to ALU alu_ctrl; registered.
- alu_result  input  WIDTH  from ALU alu_result.
- alu_zero  input  1  from ALU zero_flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_result  output  WIDTH  captured ALU result.
- rsp_zero  output  1  captured zero flag.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the response.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - If any req_valid is high, the grant g is the first valid index at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally; all other req_ready bits stay low.
  - On that edge: req_a/req_b/req_ctrl slice g loads into alu_operand_a/b and alu_ctrl, g loads into the ID register, rr_ptr becomes (g+1) mod NUM_REQ, and the FSM goes to ISSUE.
  - If no req_valid is high, the FSM stays in IDLE.
- ISSUE: one cycle with operands stable on the ALU bus; the counter loads ALU_LATENCY; next state is WAIT.
- WAIT:
  - The counter decrements each cycle. WAIT lasts exactly ALU_LATENCY cycles.
  - On the edge that ends the final WAIT cycle, alu_result and alu_zero load into rsp_result and rsp_zero; next state is RESP.
- RESP:
  - rsp_valid is high. rsp_result, rsp_zero and rsp_id are stable until the handshake completes.
  - When rsp_valid and rsp_ready are both high, the FSM goes to IDLE.
  - While rsp_ready is low, the FSM holds in RESP.
- req_ready is low in every state except IDLE, so no request is accepted while one is in flight. This includes the RESP handshake cycle: there is no overlap between a response and the next accept.
- alu_operand_a/b and alu_ctrl hold their last values outside the ISSUE and WAIT states. rsp_result, rsp_zero and rsp_id hold their last values after the handshake.
- A requester that drops req_valid before it is granted loses nothing; the next arbitration uses the current valids.
- No arithmetic is done in the arbiter; widths pass through unchanged. rr_ptr wraps from NUM_REQ-1 to 0.

## Timing
- Reset values: state IDLE, rr_ptr 0, counter 0, req_ready 0, alu_operand_a/b 0, alu_ctrl 0, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_id 0, busy 0.
- Reset asserted in any state, including mid-WAIT or mid-RESP: the block is in the reset state immediately and the in-flight operation is discarded with no response. After release, the first accept is no earlier than the first rising edge at which rst is low.
- Latency: with the accept on edge T, ISSUE is cycle T+1 and WAIT is cycles T+2 through T+1+ALU_LATENCY.
- rsp_valid first rises in cycle T+2+ALU_LATENCY, which is cycle T+3 for the default ALU_LATENCY.
- Minimum period between accepts, with rsp_ready tied high: ALU_LATENCY+3 cycles.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest-index valid requester always wins. rr_ptr is not implemented, or is held at 0.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Reset: assert rst in cycle 2 of WAIT with requester 1 in flight -> all outputs 0 on the next sample; after release no rsp_valid occurs until a new request.
- Single ADD: requester 0, a=10, b=20, ctrl=0000, accepted at edge T -> rsp_valid in cycle T+3, rsp_result=30, rsp_zero=0, rsp_id=0.
- Round-robin: all four requesters valid continuously, with SUB 30-10, AND F0F0&0FF0, SLL 1<<5 and ADD 10+20 on requesters 0..3 -> rsp_id sequence 0,1,2,3,0 with results 20, 00F0, 20 (0x20), 30, 20. With ALU_ARB_FIXED_PRIO_EN -> rsp_id always 0.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises -> rsp_valid, rsp_result and rsp_id stable and every req_ready bit 0 throughout; IDLE is entered one cycle after rsp_ready goes high.
- Zero flag: SUB a=10, b=10 -> rsp_result=0, rsp_zero=1.
- Latency parameter: ALU_LATENCY=3 with ADD 10+20 accepted at edge T -> rsp_valid first high in cycle T+5, rsp_result=30.
